elink_pattern_io: RTL and testbench

- Parametrised successor to the static eLink tie-off block.
- Instead of holding the eLink TX side at constants, it drives framed bursts of a selectable test pattern and throttles on TX_WR_WAIT.
- It checks the pattern arriving on the RX side and reports error and beat counts.
- It sits on the parallel (post-IBUFDS / pre-OBUFDS) side of the eLink pins; the LVDS buffers stay outside this block.

---
 rtl/elink_pattern_io.sv | 172 +++++++++++++++++
 tb/tb_elink_pattern_io.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/elink_pattern_io.sv
// eLink pattern exerciser: emits framed bursts of a selectable test pattern on the
// TX side, throttled by tx_wr_wait, and checks/counts the pattern arriving on RX.
module elink_pattern_io #(
  parameter int DW        = 8,
  parameter int BURST_LEN = 8,
  parameter int GAP_LEN   = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic [DW-1:0]    tx_data,
  output logic             tx_frame,
  input  logic             tx_wr_wait,
  input  logic [DW-1:0]    rx_data,
  input  logic             rx_frame,
  output logic             rx_wr_wait,
  output logic             locked,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] beat_count
);

  localparam int BW = $clog2(BURST_LEN);
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'(GAP_LEN - 1);
  localparam logic [DW-1:0] ONE_D     = DW'(1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  function automatic logic [DW-1:0] seed_of(input logic [1:0] m);
    case (m)
      2'd2:    seed_of = ONE_D;
      2'd3:    seed_of = '1;
      default: seed_of = '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] advance(input logic [DW-1:0] v, input logic [1:0] m);
    case (m)
      2'd1:    advance = v + ONE_D;
      2'd2:    advance = {v[DW-2:0], v[DW-1]};
      2'd3:    advance = v - ONE_D;
      default: advance = v;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t          state;
  logic [1:0]      mode_q;
  logic [DW-1:0]   pat;
  logic [BW-1:0]   beat_idx;
  logic [GW-1:0]   gap_cnt;
  logic            wait_m, wait_s;

  logic [DW-1:0]   rx_data_p0;
  logic            rx_frame_p0;
  logic            en_p0;
  logic [DW-1:0]   expected;

  // tx_wr_wait crosses in from the remote side: two-flop synchroniser
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_m <= 1'b0;
      wait_s <= 1'b0;
    end else begin
      wait_m <= tx_wr_wait;
      wait_s <= wait_m;
    end
  end

  // TX generator FSM: bursts always run to BURST_LEN beats once started
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mode_q   <= 2'd0;
      pat      <= '0;
      beat_idx <= '0;
      gap_cnt  <= '0;
      tx_data  <= '0;
      tx_frame <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_frame <= 1'b0;
          beat_idx <= '0;
          gap_cnt  <= '0;
          if (enable) begin
            mode_q <= mode;
            pat    <= seed_of(mode);
            state  <= BURST;
          end
        end
        BURST: begin
          if (wait_s) begin
            tx_frame <= 1'b0;
          end else begin
            tx_data  <= pat;
            tx_frame <= 1'b1;
            pat      <= advance(pat, mode_q);
            if (beat_idx == LAST_BEAT) begin
              beat_idx <= '0;
              gap_cnt  <= '0;
              state    <= GAP;
            end else begin
              beat_idx <= beat_idx + BW'(1);
            end
          end
        end
        GAP: begin
          tx_frame <= 1'b0;
          if (gap_cnt == LAST_GAP) begin
            gap_cnt <= '0;
            state   <= enable ? BURST : IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          tx_frame <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // RX stage p0: register the incoming beat and enable for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_p0  <= '0;
      rx_frame_p0 <= 1'b0;
      en_p0       <= 1'b0;
    end else begin
      rx_data_p0  <= rx_data;
      rx_frame_p0 <= rx_frame;
      en_p0       <= enable;
    end
  end

  // RX stage p1: checker reseeds from every received beat, so one bad beat costs at most two errors
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expected   <= '0;
      locked     <= 1'b0;
      rx_wr_wait <= 1'b1;
      err_count  <= '0;
      beat_count <= '0;
    end else if (!enable) begin
      locked     <= 1'b0;
      rx_wr_wait <= 1'b1;
    end else if (!en_p0) begin
      locked     <= 1'b0;
      rx_wr_wait <= 1'b0;
      err_count  <= '0;
      beat_count <= '0;
    end else begin
      rx_wr_wait <= 1'b0;
      if (rx_frame_p0) begin
        beat_count <= sat_inc(beat_count);
        expected   <= advance(rx_data_p0, mode);
        locked     <= 1'b1;
        if (locked && (rx_data_p0 != expected))
          err_count <= sat_inc(err_count);
      end
    end
  end

endmodule

// File: tb/tb_elink_pattern_io.sv
// Scoreboarded bench for elink_pattern_io: TX beats checked against a pattern model,
// RX checker exercised through loopback with corruption, stalls and counter saturation.
module tb_elink_pattern_io;

  localparam int BL = 4;
  localparam int GL = 2;

  logic        clk = 1'b0;
  logic        reset, enable, tx_wr_wait, loop_en, corrupt_en;
  logic [1:0]  mode;
  logic [7:0]  tx_data, rx_data;
  logic        tx_frame, rx_frame, rx_wr_wait, locked;
  logic [15:0] err_count, beat_count;

  logic        sat_enable, sat_rx_frame, sat_tx_frame, sat_rx_wr_wait, sat_locked;
  logic [7:0]  sat_rx_data, sat_tx_data;
  logic [3:0]  sat_err, sat_beat;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];

  assign rx_data  = (corrupt_en && tx_data == 8'h05) ? 8'h55 : tx_data;
  assign rx_frame = tx_frame & loop_en;

  always #5 clk = ~clk;

  elink_pattern_io #(.DW(8), .BURST_LEN(BL), .GAP_LEN(GL), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .tx_data(tx_data), .tx_frame(tx_frame), .tx_wr_wait(tx_wr_wait),
    .rx_data(rx_data), .rx_frame(rx_frame), .rx_wr_wait(rx_wr_wait),
    .locked(locked), .err_count(err_count), .beat_count(beat_count)
  );

  elink_pattern_io #(.DW(8), .BURST_LEN(BL), .GAP_LEN(GL), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .enable(sat_enable), .mode(mode),
    .tx_data(sat_tx_data), .tx_frame(sat_tx_frame), .tx_wr_wait(1'b0),
    .rx_data(sat_rx_data), .rx_frame(sat_rx_frame), .rx_wr_wait(sat_rx_wr_wait),
    .locked(sat_locked), .err_count(sat_err), .beat_count(sat_beat)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // n-th value of the pattern after a fresh seed
  function automatic logic [7:0] pat_at(input logic [1:0] m, input int n);
    logic [7:0] v;
    case (m)
      2'd1:    v = 8'(n);
      2'd2:    v = 8'd1 << (n % 8);
      2'd3:    v = 8'hFF - 8'(n);
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // tx_frame after edge k+i when enable rises at edge k, with no stalls and enable dropped after three frames
  function automatic bit frame_model(input int i);
    return (i >= 1) && (((i - 1) % (BL + GL)) < BL) && (i <= 3 * BL + 2 * GL);
  endfunction

  always @(negedge clk) begin
    if (!reset && tx_frame) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL tx_extra: beat %0h emitted with no expected value", tx_data);
      end else begin
        chk("tx_data", tx_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_phase(input logic [1:0] m, input bit lp, input bit fixed,
                           input bit stall, input bit glitch, input bit corrupt);
    int n, s, cnt, cnt_early;
    bit shape_ok, stall_ok;
    logic [7:0] held;
    cnt = 0; cnt_early = 0; shape_ok = 1'b1; stall_ok = 1'b1; held = '0;
    step();
    mode = m; loop_en = lp; corrupt_en = corrupt;
    for (int j = 0; j < 64; j++) exp_q.push_back(pat_at(m, j));
    n = fixed ? 13 : int'($urandom_range(40, 20));
    s = int'($urandom_range(10, 5));
    enable = 1'b1;
    for (int i = 0; i < n + 14; i++) begin
      step();
      if (tx_frame) cnt++;
      if (fixed && (tx_frame != frame_model(i))) shape_ok = 1'b0;
      if (glitch && i == 1) mode = m ^ 2'd1;
      if (stall) begin
        if (i == s) tx_wr_wait = 1'b1;
        if (i == s + 5) tx_wr_wait = 1'b0;
        if (i == s + 2) held = tx_data;
        if (i >= s + 3 && i <= s + 7 && (tx_frame || tx_data != held)) stall_ok = 1'b0;
      end
      if (i == n - 3) cnt_early = cnt;
      if (i == n - 1) begin
        chk("err_live", err_count, corrupt ? 2 : 0);
        chk("locked_live", locked, lp);
        chk("beat_live", beat_count, lp ? cnt_early : 0);
        chk("rx_wr_wait_live", rx_wr_wait, 0);
      end
      if (i == n) enable = 1'b0;
    end
    chk("whole_frames", cnt % BL, 0);
    chk("q_left", exp_q.size(), 64 - cnt);
    if (fixed) begin
      chk("burst_count", cnt, 3 * BL);
      chk("frame_shape", shape_ok, 1);
    end
    if (stall) chk("stall_hold", stall_ok, 1);
    chk("idle_frame", tx_frame, 0);
    chk("idle_rx_wr_wait", rx_wr_wait, 1);
    chk("idle_locked", locked, 0);
    exp_q.delete();
    mode = m; corrupt_en = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 2'd0; tx_wr_wait = 1'b0;
    loop_en = 1'b0; corrupt_en = 1'b0;
    sat_enable = 1'b0; sat_rx_frame = 1'b0; sat_rx_data = '0;
    step(); step();
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_frame", tx_frame, 0);
    chk("rst_rx_wr_wait", rx_wr_wait, 1);
    chk("rst_locked", locked, 0);
    chk("rst_err", err_count, 0);
    chk("rst_beat", beat_count, 0);
    reset = 1'b0;
    step();

    run_phase(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_phase(2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_phase(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_phase(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_phase(2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_phase(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++)
      run_phase(2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1'b0,
                1'($urandom_range(1, 0)), 1'b0, 1'b0);

    // saturation on the narrow-counter instance
    mode = 2'd1;
    sat_enable = 1'b1;
    step();
    sat_rx_frame = 1'b1; sat_rx_data = 8'h00;
    repeat (20) step();
    sat_rx_frame = 1'b0;
    repeat (3) step();
    chk("sat_err", sat_err, 4'hF);
    chk("sat_beat", sat_beat, 4'hF);
    chk("sat_locked", sat_locked, 1);
    sat_enable = 1'b0;
    repeat (2) step();
    chk("sat_off_locked", sat_locked, 0);
    chk("sat_off_rx_wr_wait", sat_rx_wr_wait, 1);
    chk("sat_off_err_hold", sat_err, 4'hF);
    sat_enable = 1'b1;
    repeat (2) step();
    chk("sat_clr_err", sat_err, 0);
    chk("sat_clr_beat", sat_beat, 0);
    chk("sat_clr_locked", sat_locked, 0);
    chk("sat_clr_rx_wr_wait", sat_rx_wr_wait, 0);
    sat_enable = 1'b0;

    // asynchronous reset in the middle of a burst
    mode = 2'd1; loop_en = 1'b1;
    for (int j = 0; j < 64; j++) exp_q.push_back(pat_at(2'd1, j));
    enable = 1'b1;
    repeat (10) step();
    chk("pre_reset_locked", locked, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_tx_frame", tx_frame, 0);
    chk("mid_rst_rx_wr_wait", rx_wr_wait, 1);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_beat", beat_count, 0);
    enable = 1'b0;
    exp_q.delete();
    step();
    reset = 1'b0;
    repeat (4) step();
    chk("post_rst_frame", tx_frame, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
